// File: rtl/power_estimate_engine_if.sv
// Register-bank side bundle for the power estimate engine: run controls and
// coefficients in, published estimate and status out.
interface power_estimate_engine_if #(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned COEF_WIDTH = 16
);
  logic                          enable;
  logic [31:0]                   window_len;
  logic [NUM_CNT-1:0]            act_pulse;
  logic [NUM_CNT*COEF_WIDTH-1:0] coef;
  logic [31:0]                   intercept;
  logic                          sat_clr;
  logic [31:0]                   est_data;
  logic                          est_valid;
  logic [31:0]                   est_seq;
  logic                          est_sat;
  logic                          busy;

  // Register bank / activity sources
  modport master (
    output enable, window_len, act_pulse, coef, intercept, sat_clr,
    input  est_data, est_valid, est_seq, est_sat, busy
  );

  // Estimate engine
  modport slave (
    input  enable, window_len, act_pulse, coef, intercept, sat_clr,
    output est_data, est_valid, est_seq, est_sat, busy
  );
endinterface

// File: rtl/power_estimate_engine.sv
// Windowed activity counter with a serial multiply-accumulate power estimate:
// est = intercept + sum(coef[i] * count[i]), saturated to 32 bits on publish.
module power_estimate_engine #(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input logic                    ACLK,
  input logic                    ARESET,
  power_estimate_engine_if.slave bus
);

  localparam int unsigned          IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam logic [31:0]          MIN_LEN  = 32'(NUM_CNT + 3);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CNT - 1);

  typedef enum logic [1:0] {IDLE, MAC, ADD, PUB} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [31:0]            wcnt;
  logic [31:0]            eff_len;
  logic                   snapshot;
  logic [CNT_WIDTH-1:0]   cnt     [NUM_CNT];
  logic [CNT_WIDTH-1:0]   snap    [NUM_CNT];
  logic [COEF_WIDTH-1:0]  coef_a  [NUM_CNT];
  logic [IDX_W-1:0]       idx;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   product;
  logic                   acc_sat;

  // Effective window length and window-close detect; >= lets a shortened
  // window close immediately instead of running wcnt round to 2^32.
  always_comb begin
    eff_len  = (bus.window_len > MIN_LEN) ? bus.window_len : MIN_LEN;
    snapshot = bus.enable && (wcnt >= eff_len - 32'd1);
  end

  // Unpack the flat coefficient bus and form the current MAC term
  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      coef_a[i] = bus.coef[i*COEF_WIDTH +: COEF_WIDTH];
    end
    product = ACC_WIDTH'(snap[idx]) * ACC_WIDTH'(coef_a[idx]);
    acc_sat = |acc[ACC_WIDTH-1:32];
  end

  // Window counter: free-runs while enabled, restarts at each snapshot
  always_ff @(posedge ACLK) begin
    if (ARESET || !bus.enable || snapshot) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 32'd1;
    end
  end

  // Saturating event counters; the pulse in the snapshot cycle is folded
  // into the snapshot of the closing window
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        if (!bus.enable) begin
          cnt[i] <= '0;
        end else if (snapshot) begin
          snap[i] <= (bus.act_pulse[i] && cnt[i] != CNT_MAX) ?
                     cnt[i] + CNT_WIDTH'(1) : cnt[i];
          cnt[i]  <= '0;
        end else if (bus.act_pulse[i] && cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snapshot) state_nxt = MAC;
      MAC:     if (idx == LAST_IDX) state_nxt = ADD;
      ADD:     state_nxt = PUB;
      PUB:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Accumulator datapath and published results; est_valid is registered
  // alongside est_data/est_seq so all three change on the same edge
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc           <= '0;
      idx           <= '0;
      bus.est_data  <= '0;
      bus.est_valid <= 1'b0;
      bus.est_seq   <= '0;
      bus.est_sat   <= 1'b0;
    end else begin
      bus.est_valid <= 1'b0;
      if (state == PUB && acc_sat) begin
        bus.est_sat <= 1'b1;
      end else if (bus.sat_clr) begin
        bus.est_sat <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (snapshot) begin
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + product;
          idx <= idx + IDX_W'(1);
        end
        ADD: begin
          acc <= acc + ACC_WIDTH'(bus.intercept);
        end
        PUB: begin
          bus.est_data  <= acc_sat ? 32'hFFFF_FFFF : acc[31:0];
          bus.est_valid <= 1'b1;
          bus.est_seq   <= bus.est_seq + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_power_estimate_engine.sv
// Scoreboard bench for power_estimate_engine: stimulus pushes the expected
// estimate, sequence number, sticky flag and arrival cycle; a negedge monitor
// pops and compares whenever est_valid is seen.
// Counter width is reduced to 8 bits so counter saturation is reached in a
// few hundred cycles.
module tb_power_estimate_engine;

  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic [31:0] data;
    logic [31:0] seq;
    logic        sat;
    int unsigned cyc;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned k;
  exp_t        sb [$];

  power_estimate_engine_if #(.NUM_CNT(4), .COEF_WIDTH(16)) bus ();

  power_estimate_engine #(
    .NUM_CNT(4), .CNT_WIDTH(CNT_W), .COEF_WIDTH(16), .ACC_WIDTH(48)
  ) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] s, input logic st,
                      input int unsigned c);
    exp_t e;
    e.data = d; e.seq = s; e.sat = st; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every est_valid must match the oldest expected publication
  always @(negedge ACLK) begin
    if (!ARESET && bus.est_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: est_valid=1 at cycle %0d, none expected (est_data=%0h)",
                 cyc, bus.est_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("est_data", bus.est_data, e.data);
        chk("est_seq", bus.est_seq, e.seq);
        chk("est_sat", bus.est_sat, e.sat);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    // Reset with random inputs
    ARESET         = 1'b1;
    bus.enable     = 1'($urandom);
    bus.window_len = $urandom;
    bus.act_pulse  = 4'($urandom);
    bus.coef       = {$urandom, $urandom};
    bus.intercept  = $urandom;
    bus.sat_clr    = 1'($urandom);
    step(3);
    @(negedge ACLK);
    chk("reset_est_data", bus.est_data, 0);
    chk("reset_est_valid", bus.est_valid, 0);
    chk("reset_est_seq", bus.est_seq, 0);
    chk("reset_est_sat", bus.est_sat, 0);
    chk("reset_busy", bus.busy, 0);
    step(1);
    ARESET        = 1'b0;
    bus.enable    = 1'b0;
    bus.act_pulse = '0;
    bus.sat_clr   = 1'b0;
    step(100);
    chk("disabled_est_seq", bus.est_seq, 0);

    // Basic estimate: 100 + 5*1 + 2*4 = 113; enable dropped mid-MAC
    bus.window_len = 16;
    bus.coef       = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.intercept  = 100;
    bus.enable     = 1'b1;
    k = cyc;
    push(113, 1, 1'b0, k + 16 + 6);
    for (int j = 0; j < 16; j++) begin
      bus.act_pulse = {(j == 7 || j == 9), 2'b00, (j < 5)};
      step(1);
    end
    bus.act_pulse = '0;
    @(negedge ACLK);
    chk("busy_in_mac", bus.busy, 1);
    step(1);
    bus.enable = 1'b0;
    step(20);

    // Pulse in the snapshot cycle belongs to the closing window: 2*10 = 20,
    // then an empty window reports 0
    bus.window_len = 8;
    bus.coef       = {16'd0, 16'd0, 16'd10, 16'd0};
    bus.intercept  = 0;
    bus.enable     = 1'b1;
    k = cyc;
    push(20, 2, 1'b0, k + 8 + 6);
    push(0, 3, 1'b0, k + 16 + 6);
    for (int j = 0; j < 16; j++) begin
      bus.act_pulse = {2'b00, (j == 2 || j == 7), 1'b0};
      step(1);
    end
    bus.act_pulse = '0;
    bus.enable    = 1'b0;
    step(20);

    // window_len=0 clamps to 7-cycle windows: 5 + 7*1 = 12 every 7 cycles
    bus.window_len = 0;
    bus.coef       = {16'd0, 16'd0, 16'd0, 16'd1};
    bus.intercept  = 5;
    bus.enable     = 1'b1;
    k = cyc;
    push(12, 4, 1'b0, k + 7 + 6);
    push(12, 5, 1'b0, k + 14 + 6);
    push(12, 6, 1'b0, k + 21 + 6);
    bus.act_pulse = 4'b0001;
    step(21);
    bus.act_pulse = '0;
    bus.enable    = 1'b0;
    step(20);

    // Counter saturation: 300 pulses into an 8-bit counter -> 255
    bus.window_len = 300;
    bus.intercept  = 0;
    bus.enable     = 1'b1;
    k = cyc;
    push(255, 7, 1'b0, k + 300 + 6);
    bus.act_pulse = 4'b0001;
    step(300);
    bus.act_pulse = '0;
    bus.enable    = 1'b0;
    step(20);

    // Accumulator saturation, sticky flag, then clear
    bus.window_len = 20;
    bus.coef       = '1;
    bus.intercept  = 32'hFFFF_FFFF;
    bus.enable     = 1'b1;
    k = cyc;
    push(32'hFFFF_FFFF, 8, 1'b1, k + 20 + 6);
    bus.act_pulse = '1;
    step(20);
    bus.act_pulse = '0;
    bus.enable    = 1'b0;
    step(10);
    chk("sat_sticky", bus.est_sat, 1);
    bus.sat_clr = 1'b1;
    step(1);
    bus.sat_clr = 1'b0;
    @(negedge ACLK);
    chk("sat_cleared", bus.est_sat, 0);
    chk("est_data_held", bus.est_data, 32'hFFFF_FFFF);
    step(1);

    // Reset in the middle of MAC abandons the estimate
    bus.window_len = 8;
    bus.coef       = {16'd0, 16'd0, 16'd0, 16'd1};
    bus.intercept  = 0;
    bus.enable     = 1'b1;
    bus.act_pulse  = 4'b0001;
    step(8);
    bus.act_pulse = '0;
    step(2);
    ARESET = 1'b1;
    step(1);
    ARESET     = 1'b0;
    bus.enable = 1'b0;
    step(20);
    chk("midmac_reset_seq", bus.est_seq, 0);
    chk("midmac_reset_data", bus.est_data, 0);
    chk("midmac_reset_busy", bus.busy, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/power_estimate_engine.md
Name: power_estimate_engine

Overview:
- Upstream feeder for the PowerMonitoringIP AXI4-Lite register bank.
- Counts per-signal activity events over a programmable window of ACLK cycles.
- At the end of each window, computes a linear power estimate, est = intercept + sum(coef[i] * count[i]), using one serial multiply-accumulate stage.
- Publishes the estimate, a window sequence count and a sticky saturation flag; the register bank latches these for software reads.

Parameters:
- NUM_CNT, 4: number of activity inputs / coefficients.
- CNT_WIDTH, 16: per-input event counter width (saturating).
- COEF_WIDTH, 16: unsigned coefficient width.
- ACC_WIDTH, 48: internal accumulator width; must be >= CNT_WIDTH+COEF_WIDTH+clog2(NUM_CNT)+1.

Ports:
- ACLK, input, 1: sole clock; all logic rising-edge.
- ARESET, input, 1: synchronous, active-high reset.
- enable, input, 1: run control from register bank.
- window_len, input, 32: window length in ACLK cycles; effective value = max(window_len, NUM_CNT+3).
- act_pulse, input, NUM_CNT: one-cycle activity events, bit i = input i.
- coef, input, NUM_CNT*COEF_WIDTH: coefficients; coef[i] = bits [i*COEF_WIDTH +: COEF_WIDTH].
- intercept, input, 32: static-power term, zero-extended into the accumulator.
- sat_clr, input, 1: clears est_sat.
- est_data, output, 32: last published estimate (held).
- est_valid, output, 1: one-cycle strobe when est_data updates.
- est_seq, output, 32: count of published estimates, wraps at 2^32.
- est_sat, output, 1: sticky; set when any estimate saturated.
- busy, output, 1: high while in MAC, ADD or PUB.

Behaviour:
- Reset (ARESET=1 at a clock edge): clear every register to 0 in that cycle. This covers all outputs, the window counter, event counters, snapshots, accumulator and FSM (to IDLE). Reset mid-computation abandons it with no est_valid.
- Window counter wcnt:
  - While enable=1, increments each cycle.
  - On the cycle wcnt == eff_len-1 (the "snapshot cycle"), wcnt returns to 0.
  - enable=0: wcnt and all event counters clear to 0 next cycle; no snapshot is taken.
  - An in-flight computation still completes and publishes.
- Event counters cnt[i]:
  - +1 on each cycle with act_pulse[i]=1 and enable=1.
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - In the snapshot cycle: snap[i] <= saturating(cnt[i] + act_pulse[i]) and cnt[i] <= 0. The pulse in the snapshot cycle belongs to the closing window.
- eff_len changes take effect on the next compare; if wcnt already >= the new eff_len-1, wcnt continues to 2^32-1 and wraps.
  - Spec decision: instead, compare with wcnt >= eff_len-1 so the window closes immediately.
- Coefficients and intercept are sampled on each MAC/ADD cycle; software changes them only while enable=0.
- FSM:
  - IDLE: on snapshot, acc <= 0, idx <= 0 -> MAC.
  - MAC: acc <= acc + snap[idx]*coef[idx]; idx++. After idx = NUM_CNT-1 -> ADD. Takes NUM_CNT cycles.
  - ADD: acc <= acc + intercept -> PUB.
  - PUB:
    - est_data <= (acc > 2^32-1) ? 32'hFFFFFFFF : acc[31:0].
    - est_sat set if saturated.
    - est_valid=1 for this single cycle; est_seq <= est_seq+1.
    - -> IDLE.
- Latency: est_valid asserts exactly NUM_CNT+2 cycles after the snapshot cycle (6 with defaults).
- eff_len >= NUM_CNT+3 guarantees the FSM is in IDLE at every snapshot; no overrun path exists.
- est_sat: set in PUB on saturation; cleared by sat_clr. If both occur in the same cycle, set wins.
- All arithmetic is unsigned; there are no X outputs after reset.

Test Plan:
- Reset: drive ARESET=1 with random inputs -> all outputs 0, busy=0. Release, enable=0 for 100 cycles -> no est_valid.
- Basic estimate:
  - Setup: window_len=16, coef={4,3,2,1} (coef[0]=1), intercept=100, enable=1.
  - Stimulus: act_pulse[0] on 5 cycles and act_pulse[3] on 2 cycles within the window.
  - Expected: est_data=100+5*1+2*4=113, est_valid at snapshot+6, est_seq=1.
- Snapshot-cycle pulse and consecutive windows:
  - Stimulus: pulse bit1 exactly in the snapshot cycle, coef[1]=10, intercept=0.
  - Expected: that window reports 10 (counting its other pulses); the next window with no pulses reports 0 with est_seq incremented.
- Counter saturation: hold act_pulse[0]=1 with window_len=70000, coef[0]=1, intercept=0 -> est_data=65535.
- Accumulator saturation: coef all 16'hFFFF, all pulses continuous, window_len=65536, intercept=32'hFFFFFFFF -> est_data=FFFFFFFF, est_sat=1. Then sat_clr -> est_sat=0.
- Boundary and control:
  - window_len=0 -> windows of 7 cycles (est_valid period 7).
  - Deassert enable mid-MAC -> that estimate still publishes; afterwards no further est_valid; counters read 0 when re-enabled.
  - ARESET mid-MAC -> no est_valid, est_seq stays 0.
